// File: rtl/dsp_pipe_reg.sv
// Elastic DEPTH-stage valid/ready register with bubble collapse and flush.
// Define DSP_PIPE_OCC_EN to add the registered occupancy counter port.
module dsp_pipe_reg #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2
`ifdef DSP_PIPE_OCC_EN
  ,
  localparam int OW = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DSP_PIPE_OCC_EN
  ,
  output logic [OW-1:0]    occupancy
`endif
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused;
      assign unused    = ^{clk, rst_n, flush};
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready;
`ifdef DSP_PIPE_OCC_EN
      assign occupancy = '0;
`endif
    end else begin : g_pipe
      logic [DEPTH-1:0] v;
      logic [DEPTH-1:0] a;
      logic [DEPTH:0]   vs;
      logic [WIDTH-1:0] d  [DEPTH];
      logic [WIDTH-1:0] ds [DEPTH+1];
      logic             in_fire;

      // A stage may move if anything at or past it is a bubble.
      for (genvar i = 0; i < DEPTH; i++) begin : g_adv
        assign a[i]     = out_ready || !(&v[DEPTH-1:i]);
        assign vs[i+1]  = v[i];
        assign ds[i+1]  = d[i];
      end

      assign in_ready  = a[0] && !flush;
      assign in_fire   = in_valid && in_ready;
      assign vs[0]     = in_fire;
      assign ds[0]     = in_data;
      assign out_valid = v[DEPTH-1];
      assign out_data  = d[DEPTH-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            d[i] <= '0;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
              v[i] <= 1'b0;
            end else if (a[i]) begin
              v[i] <= vs[i];
              if (vs[i]) begin
                d[i] <= ds[i];
              end
            end
          end
        end
      end

`ifdef DSP_PIPE_OCC_EN
      localparam logic [OW-1:0] ONE = 1;
      logic [OW-1:0] occ;
      logic          out_fire;

      assign out_fire  = out_valid && out_ready;
      assign occupancy = occ;

      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          occ <= '0;
        end else if (in_fire && !out_fire) begin
          occ <= occ + ONE;
        end else if (!in_fire && out_fire) begin
          occ <= occ - ONE;
        end
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Randomized and directed checks of dsp_pipe_reg against a
// word-position queue model; also checks the DEPTH=0 pass-through.
module tb_dsp_pipe_reg;
  localparam int W = 18;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] out_data;
  logic         in_ready;
  logic         out_valid;

  logic [7:0]   z_in = '0;
  logic [7:0]   z_out;
  logic         z_iv = 1'b0;
  logic         z_or = 1'b0;
  logic         z_ir;
  logic         z_ov;
`ifdef DSP_PIPE_OCC_EN
  logic [1:0]   occ;
  logic         z_occ;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] qd[$];
  int           qp[$];

  always #5 clk = ~clk;

  dsp_pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef DSP_PIPE_OCC_EN
    , .occupancy(occ)
`endif
  );

  dsp_pipe_reg #(.WIDTH(8), .DEPTH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(z_iv), .in_ready(z_ir), .in_data(z_in),
    .out_valid(z_ov), .out_ready(z_or), .out_data(z_out)
`ifdef DSP_PIPE_OCC_EN
    , .occupancy(z_occ)
`endif
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive, check against model, clock, advance model.
  task automatic cyc(bit rn, bit fl, bit iv, logic [W-1:0] id, bit ordy);
    bit ev, er, ofire, ifire;
    int lim, np;
    rst_n = rn; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    ev = (qd.size() > 0) && (qp[0] == D - 1);
    er = ((qd.size() < D) || ordy) && !fl;
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, ev);
    if (ev) check("out_data", out_data, qd[0]);
`ifdef DSP_PIPE_OCC_EN
    check("occupancy", occ, qd.size());
`endif
    @(posedge clk);
    if (!rn || fl) begin
      qd.delete();
      qp.delete();
    end else begin
      ofire = ev && ordy;
      ifire = iv && er;
      if (ofire) begin
        void'(qd.pop_front());
        void'(qp.pop_front());
      end
      lim = D - 1;
      foreach (qp[k]) begin
        np = (qp[k] + 1 > lim) ? lim : qp[k] + 1;
        qp[k] = np;
        lim = np - 1;
      end
      if (ifire) begin
        qd.push_back(id);
        qp.push_back(0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // streaming
    for (int i = 1; i <= 4; i++) cyc(1, 0, 1, W'(i), 1);
    repeat (4) cyc(1, 0, 0, '0, 1);

    // backpressure
    cyc(1, 0, 1, 'h00A, 0);
    cyc(1, 0, 1, 'h00B, 0);
    cyc(1, 0, 1, 'h00C, 0);
    repeat (2) cyc(1, 0, 1, 'h00D, 0);
    cyc(1, 0, 1, 'h00D, 1);
    repeat (5) cyc(1, 0, 0, '0, 1);

    // bubble collapse
    cyc(1, 0, 1, 'h111, 0);
    cyc(1, 0, 0, '0, 0);
    cyc(1, 0, 1, 'h222, 0);
    repeat (3) cyc(1, 0, 0, '0, 0);

    // flush with two words held
    cyc(1, 1, 1, 'h333, 0);
    repeat (2) cyc(1, 0, 0, '0, 1);

    // reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, W'('h770 + i), 0);
    cyc(0, 0, 1, 'h777, 0);
    check("midrst_out_data", out_data, 0);
    cyc(1, 0, 1, 'h0AB, 1);
    repeat (4) cyc(1, 0, 0, '0, 1);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      cyc(($urandom % 100) != 0, ($urandom % 25) == 0,
          ($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0);
    end

    // DEPTH=0 pass-through
    z_in = 8'h5A; z_iv = 1'b1; z_or = 1'b0;
    #1;
    check("p0_data", z_out, 8'h5A);
    check("p0_valid", z_ov, 1);
    check("p0_ready", z_ir, 0);
    for (int n = 0; n < 8; n++) begin
      logic [7:0] x;
      logic iv, orr;
      x = 8'($urandom); iv = 1'($urandom); orr = 1'($urandom);
      z_in = x; z_iv = iv; z_or = orr;
      #1;
      check("p0r_data", z_out, x);
      check("p0r_valid", z_ov, iv);
      check("p0r_ready", z_ir, orr);
`ifdef DSP_PIPE_OCC_EN
      check("p0r_occ", z_occ, 0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
